// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin share of one UART transmitter among NUM_REQ byte producers.
// Latency : req seen in IDLE -> ack/transmit/TxData registered on the next edge.
// Backpres: grants only while the transmitter is idle; one frame in flight at a time.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                          tx_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         TxData,
    output logic                          transmit,
    input  logic                          busy,
    output logic [ID_W-1:0]               active_id,
    output logic                          tx_active,
    output logic                          start_err
);

    // Launch watchdog counts 0 .. START_TIMEOUT-1 inclusive.
    localparam int                CNT_W     = $clog2(START_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(START_TIMEOUT - 1);
    localparam logic [ID_W:0]     NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    // Round-robin pointer: the requester searched first on the next grant.
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         ptr_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;

    logic [NUM_REQ-1:0]      ack_nxt;
    logic [DATA_WIDTH-1:0]   txdata_nxt;
    logic                    transmit_nxt;
    logic [ID_W-1:0]         id_nxt;
    logic                    err_nxt;

    // Grant search results.
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W:0]           scan_idx;

    // Find the first set request at or after ptr, wrapping; smallest offset wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (req[scan_idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        ack_nxt      = '0;
        txdata_nxt   = TxData;
        transmit_nxt = transmit;
        id_nxt       = active_id;
        err_nxt      = 1'b0;

        case (state)
            IDLE: begin
                transmit_nxt = 1'b0;
                // A busy transmitter blocks granting entirely, even if it is
                // about to fall this same cycle.
                if (!busy && grant_vld) begin
                    txdata_nxt   = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
                    id_nxt       = grant_id;
                    ack_nxt      = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
                    transmit_nxt = 1'b1;
                    cnt_nxt      = '0;
                    ptr_nxt      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    state_nxt    = LAUNCH;
                end
            end

            LAUNCH: begin
                if (busy) begin
                    transmit_nxt = 1'b0;
                    state_nxt    = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    // Transmitter never answered: drop the byte, no retry.
                    transmit_nxt = 1'b0;
                    err_nxt      = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                transmit_nxt = 1'b0;
                if (!busy) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                transmit_nxt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything including the pointer.
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            ack       <= '0;
            TxData    <= '0;
            transmit  <= 1'b0;
            active_id <= '0;
            tx_active <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            ack       <= ack_nxt;
            TxData    <= txdata_nxt;
            transmit  <= transmit_nxt;
            active_id <= id_nxt;
            tx_active <= (state_nxt != IDLE);
            start_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Transmitter raises busy 3 cycles after seeing transmit and holds it 20 cycles.
// Busy can instead be forced from the stimulus when the model is disabled.
module tb_uart_tx_arbiter;

    localparam int DW   = 8;
    localparam int NR   = 4;
    localparam int IW   = 2;
    localparam int DLY  = 3;
    localparam int HOLD = 20;

    logic              tx_clk;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     ack;
    logic [DW-1:0]     TxData;
    logic              transmit;
    logic              busy;
    logic [IW-1:0]     active_id;
    logic              tx_active;
    logic              start_err;

    logic              model_en;
    logic              model_busy;
    logic              ext_busy;
    int                dcnt;
    int                hcnt;

    int                n_assert = 0;
    int                n_fail   = 0;

    uart_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .NUM_REQ      (NR),
        .START_TIMEOUT(16)
    ) dut (
        .tx_clk   (tx_clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .TxData   (TxData),
        .transmit (transmit),
        .busy     (busy),
        .active_id(active_id),
        .tx_active(tx_active),
        .start_err(start_err)
    );

    assign busy = model_en ? model_busy : ext_busy;

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    // Transmitter model: busy appears in the 3rd cycle after transmit rises.
    always @(posedge tx_clk) begin
        if (!model_en) begin
            model_busy <= 1'b0;
            dcnt       <= 0;
            hcnt       <= 0;
        end else if (!model_busy) begin
            if (transmit) begin
                if (dcnt == DLY - 1) begin
                    model_busy <= 1'b1;
                    hcnt       <= 0;
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
        end else begin
            if (hcnt == HOLD - 1) begin
                model_busy <= 1'b0;
                dcnt       <= 0;
            end else begin
                hcnt <= hcnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until an ack appears; n = cycles taken, capped at 200.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < 200);
    endtask

    // Count cycles transmit stays high starting from the current cycle.
    task automatic measure(output int n, output int errs);
        n    = 0;
        errs = 0;
        while (transmit === 1'b1 && n < 200) begin
            n++;
            if (start_err) errs++;
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (tx_active && k < 200) begin
            tick();
            k++;
        end
        check(tag, 32'(tx_active), 32'h0);
    endtask

    logic [DW-1:0] rr_byte [5];
    logic [IW-1:0] rr_id   [5];

    initial begin
        int n;
        int errs;
        int acks;

        rr_byte[0] = 8'h4E; rr_byte[1] = 8'h52; rr_byte[2] = 8'h49;
        rr_byte[3] = 8'h51; rr_byte[4] = 8'h4E;
        rr_id[0] = 2'd0; rr_id[1] = 2'd1; rr_id[2] = 2'd2;
        rr_id[3] = 2'd3; rr_id[4] = 2'd0;

        reset    = 1'b0;
        req      = '0;
        req_data = {8'h51, 8'h49, 8'h52, 8'h45};
        model_en = 1'b1;
        ext_busy = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ack",       32'(ack),       32'h0);
        check("rst_txdata",    32'(TxData),    32'h0);
        check("rst_transmit",  32'(transmit),  32'h0);
        check("rst_active_id", 32'(active_id), 32'h0);
        check("rst_tx_active", 32'(tx_active), 32'h0);
        check("rst_start_err", 32'(start_err), 32'h0);
        reset = 1'b1;
        tick();

        // Single request, byte 'E'
        req = 4'b0001;
        wait_ack(n);
        check("single_latency",   32'(n),         32'd1);
        check("single_ack",       32'(ack),       32'h1);
        check("single_txdata",    32'(TxData),    32'h45);
        check("single_id",        32'(active_id), 32'h0);
        check("single_transmit",  32'(transmit),  32'h1);
        check("single_tx_active", 32'(tx_active), 32'h1);
        tick();
        req = 4'b0000;
        check("single_ack_pulse", 32'(ack),       32'h0);
        measure(n, errs);
        // one transmit cycle already consumed before measure
        check("single_tx_cycles", 32'(n + 1),     32'd4);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("single_active_at_busy_fall", 32'(tx_active), 32'h1);
        tick();
        check("single_active_after",        32'(tx_active), 32'h0);

        // Round robin from pointer 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_data = {8'h51, 8'h49, 8'h52, 8'h4E};
        req      = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(n);
            check("rr_ack",    32'(ack),       32'(4'b0001 << rr_id[g]));
            check("rr_id",     32'(active_id), 32'(rr_id[g]));
            check("rr_txdata", 32'(TxData),    32'(rr_byte[g]));
        end
        req = 4'b0000;
        wait_idle("rr_idle");

        // Pointer wrap: grant 3, then 1001 -> 0 then 3
        req = 4'b1000;
        wait_ack(n);
        check("wrap_first_id", 32'(active_id), 32'h3);
        req = 4'b0000;
        wait_idle("wrap_idle1");
        req = 4'b1001;
        wait_ack(n);
        check("wrap_id0", 32'(active_id), 32'h0);
        wait_ack(n);
        check("wrap_id3", 32'(active_id), 32'h3);
        req = 4'b0000;
        wait_idle("wrap_idle2");

        // Start timeout: busy held low
        model_en = 1'b0;
        ext_busy = 1'b0;
        req      = 4'b0010;
        wait_ack(n);
        check("to_latency", 32'(n),         32'd1);
        check("to_id",      32'(active_id), 32'h1);
        measure(n, errs);
        check("to_tx_cycles",     32'(n),         32'd16);
        check("to_err_in_launch", 32'(errs),      32'h0);
        check("to_start_err",     32'(start_err), 32'h1);
        check("to_tx_active",     32'(tx_active), 32'h0);
        tick();
        check("to_regrant_ack",   32'(ack),       32'h2);
        check("to_err_pulse",     32'(start_err), 32'h0);
        check("to_regrant_tx",    32'(transmit),  32'h1);
        req = 4'b0000;
        wait_idle("to_idle");

        // Busy-gated grant
        ext_busy = 1'b1;
        req      = 4'b0100;
        acks     = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack != '0) acks++;
        end
        check("bg_no_ack",    32'(acks),      32'h0);
        check("bg_no_active", 32'(tx_active), 32'h0);
        ext_busy = 1'b0;
        wait_ack(n);
        check("bg_latency", 32'(n),         32'd1);
        check("bg_id",      32'(active_id), 32'h2);
        check("bg_ack",     32'(ack),       32'h4);
        req      = 4'b0000;
        model_en = 1'b1;
        wait_idle("bg_idle");

        // Reset in WAIT_DONE
        req = 4'b1111;
        wait_ack(n);
        check("mr_id", 32'(active_id), 32'h3);
        req = 4'b0000;
        measure(n, errs);
        check("mr_tx_cycles", 32'(n),         32'd4);
        check("mr_in_frame",  32'(tx_active), 32'h1);
        reset = 1'b0;
        #1;
        check("mr_transmit",  32'(transmit),  32'h0);
        check("mr_tx_active", 32'(tx_active), 32'h0);
        check("mr_id_clear",  32'(active_id), 32'h0);
        model_en = 1'b0;
        tick();
        tick();
        reset    = 1'b1;
        model_en = 1'b1;
        req      = 4'b1111;
        wait_ack(n);
        check("mr_latency", 32'(n),         32'd1);
        check("mr_ack",     32'(ack),       32'h1);
        check("mr_txdata",  32'(TxData),    32'h4E);
        req = 4'b0000;
        wait_idle("mr_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
